// File: rtl/adc_capture_pkg.sv
// Shared definitions for the triggered dual-channel ADC capture block:
// default geometry, FSM state encoding and the active-low LED pattern per state.
package adc_capture_pkg;

  localparam int ADC_DATA_W = 10;
  localparam int ADC_DEPTH  = 32;
  localparam int ADC_ADDR_W = $clog2(ADC_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [3:0] LED_IDLE    = 4'b1110;
  localparam logic [3:0] LED_WAIT    = 4'b1101;
  localparam logic [3:0] LED_CAPTURE = 4'b1011;
  localparam logic [3:0] LED_DONE    = 4'b0111;

  function automatic logic [3:0] led_code(input state_t s);
    case (s)
      S_IDLE:    return LED_IDLE;
      S_WAIT:    return LED_WAIT;
      S_CAPTURE: return LED_CAPTURE;
      default:   return LED_DONE;
    endcase
  endfunction

endpackage

// File: rtl/adc_capture_if.sv
// Signal bundle between the capture block (slave) and the ADC module plus
// host/debug logic (master): ADC bus, trigger controls, readback and status.
interface adc_capture_if #(
  parameter int DATA_W = adc_capture_pkg::ADC_DATA_W,
  parameter int ADDR_W = adc_capture_pkg::ADC_ADDR_W
);
  logic              adc_clk1;
  logic              adc_clk2;
  logic [DATA_W-1:0] adc_d1;
  logic [DATA_W-1:0] adc_d2;
  logic              arm;
  logic              force_trig;
  logic              trig_rise;
  logic [DATA_W-1:0] trig_level;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy;
  logic              done;
  logic [3:0]        LED;

  modport slave (
    input  adc_d1, adc_d2, arm, force_trig, trig_rise, trig_level, rd_addr,
    output adc_clk1, adc_clk2, rd_data1, rd_data2, busy, done, LED
  );

  modport master (
    output adc_d1, adc_d2, arm, force_trig, trig_rise, trig_level, rd_addr,
    input  adc_clk1, adc_clk2, rd_data1, rd_data2, busy, done, LED
  );
endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read-first read.
module adc_capture_ram #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reading the pre-edge array contents gives read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture.sv
// Triggered dual-channel ADC capture: input pipe, level-crossing trigger on ch1,
// capture FSM with write-address counter, and a registered buffer readback port.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int DEPTH  = ADC_DEPTH,
  parameter int ADDR_W = ADC_ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  adc_capture_if.slave   bus
);

  logic [DATA_W-1:0]   d1_q, d2_q, prev_q;
  state_t              state, state_next;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_next;
  logic                crossing, trig, wr_en;
  logic [2*DATA_W-1:0] rd_word;

  assign bus.adc_clk1 = clk;
  assign bus.adc_clk2 = clk;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q   <= '0;
      d2_q   <= '0;
      prev_q <= '0;
    end else begin
      d1_q   <= bus.adc_d1;
      d2_q   <= bus.adc_d2;
      prev_q <= d1_q;
    end
  end

  always_comb begin
    if (bus.trig_rise) crossing = (prev_q < bus.trig_level) && (d1_q >= bus.trig_level);
    else               crossing = (prev_q > bus.trig_level) && (d1_q <= bus.trig_level);
  end

  assign trig = crossing | bus.force_trig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_addr <= '0;
    end else begin
      state   <= state_next;
      wr_addr <= wr_addr_next;
    end
  end

  // NOTE: every output of this block is given a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    wr_en        = 1'b0;
    unique case (state)
      S_IDLE: if (bus.arm) state_next = S_WAIT;
      // wr_addr is always 0 here (reset or wrapped), so the trigger sample lands in buf[0].
      S_WAIT: if (trig) begin
        wr_en        = 1'b1;
        wr_addr_next = wr_addr + 1'b1;
        state_next   = S_CAPTURE;
      end
      S_CAPTURE: begin
        wr_en        = 1'b1;
        wr_addr_next = wr_addr + 1'b1;
        if (wr_addr == ADDR_W'(DEPTH - 1)) state_next = S_DONE;
      end
      S_DONE: if (bus.arm) state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  adc_capture_ram #(
    .WIDTH  (2 * DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en & ~rst),
    .waddr (wr_addr),
    .wdata ({d1_q, d2_q}),
    .raddr (bus.rd_addr),
    .rdata (rd_word)
  );

  assign bus.rd_data1 = rd_word[2*DATA_W-1:DATA_W];
  assign bus.rd_data2 = rd_word[DATA_W-1:0];
  assign bus.busy     = (state == S_WAIT) || (state == S_CAPTURE);
  assign bus.done     = (state == S_DONE);
  assign bus.LED      = led_code(state);

endmodule
